// File: rtl/traffic_pkg.sv
// State codes and lamp encodings shared by the traffic light controller and its bench.
// Lamp vectors are {red,yellow,green}.
package traffic_pkg;

   localparam logic [2:0] NS_G  = 3'd0;
   localparam logic [2:0] NS_Y  = 3'd1;
   localparam logic [2:0] RED_A = 3'd2;
   localparam logic [2:0] EW_G  = 3'd3;
   localparam logic [2:0] EW_Y  = 3'd4;
   localparam logic [2:0] RED_B = 3'd5;
   localparam logic [2:0] PED_W = 3'd6;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/tl_phase_timer.sv
// Cycles-in-state counter: 0 on the cycle after clr_i, +1 per cycle, saturates at all-ones.
// Latency one cycle (registered); no backpressure.
module tl_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/param_traffic_light_ctrl.sv
// Sensor-actuated NS/EW traffic light FSM; lamps are a Moore decode of the state register (1-cycle latency).
// No backpressure; TRAFFIC_PED_EN enables the latched pedestrian walk phase after EW service.
module param_traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int NS_GMIN = 8,
   parameter int NS_GMAX = 32,
   parameter int EW_GMIN = 4,
   parameter int EW_GMAX = 16,
   parameter int YEL_T   = 3,
   parameter int RED_T   = 2,
   parameter int PED_T   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ew_car,
   input  logic             ped_req,
   output logic [2:0]       NS_light,
   output logic [2:0]       EW_light,
   output logic             ped_walk,
   output logic [CNT_W-1:0] clk_count,
   output logic [2:0]       state,
   output logic [2:0]       prev_state
);

   localparam longint DUR_LIM = 64'(1) << CNT_W;

   if (NS_GMIN < 1 || longint'(NS_GMIN) > DUR_LIM || NS_GMAX < 1 || longint'(NS_GMAX) > DUR_LIM ||
       EW_GMIN < 1 || longint'(EW_GMIN) > DUR_LIM || EW_GMAX < 1 || longint'(EW_GMAX) > DUR_LIM ||
       YEL_T < 1 || longint'(YEL_T) > DUR_LIM || RED_T < 1 || longint'(RED_T) > DUR_LIM ||
       PED_T < 1 || longint'(PED_T) > DUR_LIM) begin : g_dur_check
      $error("param_traffic_light_ctrl: every duration must lie in 1..2**CNT_W");
   end

   localparam logic [CNT_W-1:0] NS_GMIN_C = CNT_W'(NS_GMIN - 1);
   localparam logic [CNT_W-1:0] NS_GMAX_C = CNT_W'(NS_GMAX - 1);
   localparam logic [CNT_W-1:0] EW_GMIN_C = CNT_W'(EW_GMIN - 1);
   localparam logic [CNT_W-1:0] EW_GMAX_C = CNT_W'(EW_GMAX - 1);
   localparam logic [CNT_W-1:0] YEL_C     = CNT_W'(YEL_T - 1);
   localparam logic [CNT_W-1:0] RED_C     = CNT_W'(RED_T - 1);
   localparam logic [CNT_W-1:0] PED_C     = CNT_W'(PED_T - 1);

   logic [2:0]       state_q, state_d, prev_q;
   logic             ew_dem_q, ew_dem_d, ped_dem_q, ped_dem_d;
   logic             trans;
   logic [CNT_W-1:0] cnt;

   tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (trans),
      .cnt_o (cnt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         NS_G:    if (ew_dem_q && (cnt >= NS_GMIN_C || cnt == NS_GMAX_C)) state_d = NS_Y;
         NS_Y:    if (cnt == YEL_C) state_d = RED_A;
         RED_A:   if (cnt == RED_C) state_d = EW_G;
         EW_G:    if ((cnt >= EW_GMIN_C && !ew_car) || cnt == EW_GMAX_C) state_d = EW_Y;
         EW_Y:    if (cnt == YEL_C) state_d = RED_B;
         RED_B:   if (cnt == RED_C) state_d = ped_dem_q ? PED_W : NS_G;
         PED_W:   if (cnt == PED_C) state_d = NS_G;
         default: state_d = RED_B;
      endcase
   end

   assign trans = (state_d != state_q);

   // Entering the serving phase clears its demand even if the request is still asserted.
   always_comb begin
      ew_dem_d = ew_dem_q;
      if (trans && state_d == EW_G) begin
         ew_dem_d = 1'b0;
      end else if (ew_car && state_q != EW_G) begin
         ew_dem_d = 1'b1;
      end
   end

`ifdef TRAFFIC_PED_EN
   always_comb begin
      ped_dem_d = ped_dem_q;
      if (trans && state_d == PED_W) begin
         ped_dem_d = 1'b0;
      end else if (ped_req && state_q != PED_W) begin
         ped_dem_d = 1'b1;
      end
   end
   assign ped_walk = (state_q == PED_W);
`else
   logic unused_ped_req;
   assign unused_ped_req = ped_req;
   assign ped_dem_d      = 1'b0;
   assign ped_walk       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= RED_B;
         prev_q    <= RED_B;
         ew_dem_q  <= 1'b0;
         ped_dem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ew_dem_q  <= ew_dem_d;
         ped_dem_q <= ped_dem_d;
         if (trans) prev_q <= state_q;
      end
   end

   always_comb begin
      NS_light = RED;
      EW_light = RED;
      case (state_q)
         NS_G:    NS_light = GRN;
         NS_Y:    NS_light = YEL;
         EW_G:    EW_light = GRN;
         EW_Y:    EW_light = YEL;
         default: ;
      endcase
   end

   assign clk_count  = cnt;
   assign state      = state_q;
   assign prev_state = prev_q;

endmodule

// File: tb/tb_param_traffic_light_ctrl.sv
// Scoreboard bench: stimulus queues expected state transitions, a negedge monitor pops and checks them.
module tb_param_traffic_light_ctrl;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst, ew_car, ped_req;
   logic [2:0] ns_l, ew_l, st, pst;
   logic       walk;
   logic [7:0] cnt;

   param_traffic_light_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .ew_car     (ew_car),
      .ped_req    (ped_req),
      .NS_light   (ns_l),
      .EW_light   (ew_l),
      .ped_walk   (walk),
      .clk_count  (cnt),
      .state      (st),
      .prev_state (pst)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] from;
      logic [2:0] to;
      logic [7:0] last_cnt;
   } trans_t;

   trans_t exp_q[$];
   int     n_checks = 0;
   int     n_fail = 0;
   int     walk_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [2:0] exp_ns(input logic [2:0] s);
      case (s)
         3'd0:    return GRN;
         3'd1:    return YEL;
         default: return RED;
      endcase
   endfunction

   function automatic logic [2:0] exp_ew(input logic [2:0] s);
      case (s)
         3'd3:    return GRN;
         3'd4:    return YEL;
         default: return RED;
      endcase
   endfunction

   function automatic logic exp_walk(input logic [2:0] s);
`ifdef TRAFFIC_PED_EN
      return s == 3'd6;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push(input logic [2:0] f, input logic [2:0] t, input logic [7:0] c);
      trans_t e;
      e.from = f;
      e.to = t;
      e.last_cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_sc(input logic [2:0] s, input int c, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (st == s && cnt == 8'(c)) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s: state %0d cnt %0d not reached, at state %0d cnt %0d", name, s, c, st, cnt);
   endtask

   task automatic wait_drain(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) return;
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d expected transitions never seen", name, exp_q.size());
   endtask

   task automatic check_reset(input string name);
      check({name, "_state"}, st, RED_B);
      check({name, "_prev"}, pst, RED_B);
      check({name, "_ns"}, ns_l, RED);
      check({name, "_ew"}, ew_l, RED);
      check({name, "_cnt"}, cnt, 0);
      check({name, "_walk"}, walk, 0);
   endtask

   initial begin : monitor
      logic [2:0] last_st;
      logic [7:0] last_cnt;
      trans_t     e;
      last_st = RED_B;
      last_cnt = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            last_st = st;
            last_cnt = cnt;
         end else begin
            check("ns_lamp", ns_l, exp_ns(st));
            check("ew_lamp", ew_l, exp_ew(st));
            check("ped_walk", walk, exp_walk(st));
            if (walk) walk_cycles++;
            if (st != last_st) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_transition: got %0d -> %0d, expected no transition", last_st, st);
               end else begin
                  e = exp_q.pop_front();
                  check("trans_from", last_st, e.from);
                  check("trans_to", st, e.to);
                  check("prev_state", pst, e.from);
                  check("dwell_cnt", last_cnt, e.last_cnt);
                  check("entry_cnt", cnt, 0);
               end
            end
            last_st = st;
            last_cnt = cnt;
         end
      end
   end

   initial begin
      rst = 1'b0;
      ew_car = 1'b0;
      ped_req = 1'b0;

      // Power-on reset, then no EW traffic: NS green holds and the counter saturates.
      repeat (2) tick();
      check_reset("rst0");
      push(RED_B, NS_G, 1);
      rst = 1'b1;
      repeat (300) tick();
      check("sat_state", st, NS_G);
      check("sat_cnt", cnt, 255);
      check("sat_prev", pst, RED_B);
      repeat (5) tick();
      check("sat_hold", cnt, 255);
      check("sat_queue", exp_q.size(), 0);

      // One-cycle EW car pulse early in NS green: min-green honoured, short EW green.
      rst = 1'b0;
      repeat (2) tick();
      check_reset("rst1");
      push(RED_B, NS_G, 1);
      rst = 1'b1;
      wait_sc(NS_G, 2, 10, "wait_pulse");
      ew_car = 1'b1;
      push(NS_G, NS_Y, 7);
      push(NS_Y, RED_A, 2);
      push(RED_A, EW_G, 1);
      push(EW_G, EW_Y, 3);
      push(EW_Y, RED_B, 2);
      push(RED_B, NS_G, 1);
      tick();
      ew_car = 1'b0;
      wait_drain(60, "drain_pulse");

      // EW car held: forced EW max green, demand re-latched so next NS green ends at min.
      wait_sc(NS_G, 20, 40, "wait_hold");
      ew_car = 1'b1;
      push(NS_G, NS_Y, 21);
      push(NS_Y, RED_A, 2);
      push(RED_A, EW_G, 1);
      push(EW_G, EW_Y, 15);
      push(EW_Y, RED_B, 2);
      push(RED_B, NS_G, 1);
      push(NS_G, NS_Y, 7);
      push(NS_Y, RED_A, 2);
      push(RED_A, EW_G, 1);
      push(EW_G, EW_Y, 3);
      push(EW_Y, RED_B, 2);
      push(RED_B, NS_G, 1);
      wait_sc(NS_G, 0, 60, "wait_hold_ns");
      ew_car = 1'b0;
      wait_drain(60, "drain_hold");

      // Simultaneous EW car and pedestrian request: EW served first, then walk if enabled.
      wait_sc(NS_G, 4, 20, "wait_both");
      ew_car = 1'b1;
      ped_req = 1'b1;
      push(NS_G, NS_Y, 7);
      push(NS_Y, RED_A, 2);
      push(RED_A, EW_G, 1);
      push(EW_G, EW_Y, 3);
      push(EW_Y, RED_B, 2);
`ifdef TRAFFIC_PED_EN
      push(RED_B, PED_W, 1);
      push(PED_W, NS_G, 5);
`else
      push(RED_B, NS_G, 1);
`endif
      tick();
      ew_car = 1'b0;
      ped_req = 1'b0;
      wait_drain(60, "drain_both");
`ifdef TRAFFIC_PED_EN
      check("walk_cycles", walk_cycles, 6);
`else
      check("walk_cycles", walk_cycles, 0);
`endif

      // Reset in EW yellow with fresh demands latched: all demands must be dropped.
      wait_sc(NS_G, 10, 30, "wait_mid");
      ew_car = 1'b1;
      push(NS_G, NS_Y, 11);
      push(NS_Y, RED_A, 2);
      push(RED_A, EW_G, 1);
      push(EW_G, EW_Y, 3);
      tick();
      ew_car = 1'b0;
      wait_sc(EW_Y, 0, 40, "wait_ewy");
      ew_car = 1'b1;
      ped_req = 1'b1;
      tick();
      check("mid_state", st, EW_Y);
      check("mid_cnt", cnt, 1);
      ew_car = 1'b0;
      ped_req = 1'b0;
      rst = 1'b0;
      tick();
      check_reset("rst_mid");
      check("mid_queue", exp_q.size(), 0);
      push(RED_B, NS_G, 1);
      rst = 1'b1;
      repeat (40) tick();
      check("post_state", st, NS_G);
      check("post_cnt", cnt, 38);
      check("post_prev", pst, RED_B);
      check("post_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
